// File: rtl/beam_trig_pkg.sv
// Shared widths, state encoding and width helper for the beam power trigger.
package beam_trig_pkg;

  localparam int POWBITS = 16;
  localparam int SQBITS  = 12;
  localparam int SUMBITS = 15;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_t;

  // One extra bit turns an unsigned sample into a signed baseline-removed value.
  function automatic int diff_bits(input int inbits);
    return inbits + 1;
  endfunction

endpackage

// File: rtl/beam_sq_sum.sv
// Baseline removal and per-sample square (P1), then a registered adder tree
// (P2) giving the per-clock sum of squares two clocks after dat_i.
module beam_sq_sum
  import beam_trig_pkg::*;
#(
  parameter int INBITS   = 7,
  parameter int NSAMP    = 8,
  parameter int BASELINE = 47
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [INBITS*NSAMP-1:0] dat_i,
  output logic [SUMBITS-1:0]      sum_o
);

  localparam int DBITS = diff_bits(INBITS);

  logic signed [DBITS-1:0] diff [NSAMP];
  logic [SQBITS-1:0]       sq_d [NSAMP];
  logic [SQBITS-1:0]       sq_q [NSAMP];
  logic [SUMBITS-1:0]      sum_d;
  logic [SUMBITS-1:0]      sum_q;

  // Squares wrap modulo 2^SQBITS; samples above the legal range are not clamped.
  always_comb begin
    for (int k = 0; k < NSAMP; k++) begin
      diff[k] = $signed({1'b0, dat_i[INBITS*k +: INBITS]}) - $signed(DBITS'(BASELINE));
      sq_d[k] = SQBITS'((2*DBITS)'(diff[k]) * (2*DBITS)'(diff[k]));
    end
  end

  // Adder tree over the registered squares.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NSAMP; k++) begin
      sum_d = sum_d + SUMBITS'(sq_q[k]);
    end
  end

  // P1 and P2 pipeline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSAMP; k++) begin
        sq_q[k] <= '0;
      end
      sum_q <= '0;
    end else begin
      sq_q  <= sq_d;
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/beam_power_trigger.sv
// Beam power trigger: two-clock window power of baseline-removed samples,
// compared against a programmable threshold, single-cycle trigger plus holdoff.
module beam_power_trigger #(
  parameter int          INBITS         = 7,
  parameter int          NSAMP          = 8,
  parameter int          BASELINE       = 47,
  parameter int          HOLDOFF        = 4,
  parameter logic [15:0] THRESH_DEFAULT = 16'd4000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [INBITS*NSAMP-1:0] dat_i,
  input  logic [15:0]             thresh_i,
  input  logic                    thresh_wr_i,
  output logic                    thresh_ack_o,
  output logic [15:0]             power_o,
  output logic                    trig_o
);

  import beam_trig_pkg::*;

  localparam logic [1:0] ST_WARMUP  = beam_trig_pkg::WARMUP;
  localparam logic [1:0] ST_ARMED   = beam_trig_pkg::ARMED;
  localparam logic [1:0] ST_HOLDOFF = beam_trig_pkg::HOLDOFF;

  localparam int CNTW = ($clog2(HOLDOFF + 1) > 2) ? $clog2(HOLDOFF + 1) : 2;
  localparam logic [CNTW-1:0] WARMUP_LAST  = CNTW'(2);
  localparam logic [CNTW-1:0] HOLDOFF_LOAD = CNTW'(HOLDOFF);

  logic [SUMBITS-1:0] sum;
  logic [SUMBITS-1:0] sum_prev_d, sum_prev_q;
  logic [POWBITS-1:0] power_d, power_q;
  logic [1:0]         state_d, state_q;
  logic [CNTW-1:0]    cnt_d, cnt_q;
  logic               trig_d, trig_q;
  logic [15:0]        thr_d, thr_q;
  logic [15:0]        pend_val_d, pend_val_q;
  logic               pend_d, pend_q;
  logic               ack_d, ack_q;
  logic               hit;
  logic               issue;
  logic               apply;

  beam_sq_sum #(
    .INBITS   (INBITS),
    .NSAMP    (NSAMP),
    .BASELINE (BASELINE)
  ) u_sq_sum (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .dat_i (dat_i),
    .sum_o (sum)
  );

  // Window power over the current and previous clock sums (P3).
  always_comb begin
    sum_prev_d = sum;
    power_d    = POWBITS'(sum) + POWBITS'(sum_prev_q);
    hit        = (power_q > thr_q);
  end

  // Warmup / armed / holdoff sequencing; trigger only leaves ARMED.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    case (state_q)
      ST_WARMUP: begin
        if (cnt_q == WARMUP_LAST) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNTW'(1);
        end
      end
      ST_ARMED: begin
        if (hit) begin
          trig_d  = 1'b1;
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_LOAD;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_HOLDOFF: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      default: begin
        state_d = ST_WARMUP;
        cnt_d   = '0;
      end
    endcase
  end

  // A pending threshold lands only outside holdoff and never on a trigger cycle,
  // so the compare that fires always sees a stable threshold.
  always_comb begin
    issue      = (state_q == ST_ARMED) && hit;
    apply      = pend_q && ((state_q == ST_ARMED) || (state_q == ST_WARMUP)) && !issue;
    thr_d      = thr_q;
    ack_d      = 1'b0;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (apply) begin
      thr_d  = pend_val_q;
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end else begin
      thr_d  = thr_q;
    end
    if (thresh_wr_i) begin
      pend_val_d = thresh_i;
      pend_d     = 1'b1;
    end else begin
      pend_val_d = pend_val_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_prev_q <= '0;
      power_q    <= '0;
      state_q    <= ST_WARMUP;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      thr_q      <= THRESH_DEFAULT;
      pend_val_q <= 16'd0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      sum_prev_q <= sum_prev_d;
      power_q    <= power_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig_d;
      thr_q      <= thr_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
    end
  end

  assign power_o      = power_q;
  assign trig_o       = trig_q;
  assign thresh_ack_o = ack_q;

endmodule

// File: tb/tb_beam_power_trigger.sv
// Scoreboard bench for beam_power_trigger: directed scenarios plus random
// traffic, checked against a cycle-indexed reference model of the rules.
module tb_beam_power_trigger;

  localparam int INBITS   = 7;
  localparam int NSAMP    = 8;
  localparam int W        = INBITS * NSAMP;
  localparam int BASELINE = 47;
  localparam int HOLDOFF  = 4;
  localparam int THR_DEF  = 4000;

  logic         clk;
  logic         rst;
  logic [W-1:0] dat;
  logic [15:0]  thr;
  logic         wr;
  logic         ack;
  logic [15:0]  power;
  logic         trig;

  beam_power_trigger #(
    .INBITS         (INBITS),
    .NSAMP          (NSAMP),
    .BASELINE       (BASELINE),
    .HOLDOFF        (HOLDOFF),
    .THRESH_DEFAULT (16'd4000)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dat_i        (dat),
    .thresh_i     (thr),
    .thresh_wr_i  (wr),
    .thresh_ack_o (ack),
    .power_o      (power),
    .trig_o       (trig)
  );

  typedef struct {
    int cyc;
    int power;
    int trig;
    int ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  // Reference model: k counts cycles since the reset state, hist[i] is the
  // sum of squares of the samples presented at cycle i after release.
  int m_k;
  int m_hist[$];
  int m_power;
  int m_trig;
  int m_ack;
  int m_active;
  int m_pend;
  int m_pend_val;
  int m_last_trig;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clk_sum(input logic [W-1:0] d);
    int s = 0;
    for (int i = 0; i < NSAMP; i++) begin
      int v = int'(d[i*INBITS +: INBITS]);
      s += ((v - BASELINE) * (v - BASELINE)) % 4096;
    end
    return s % 32768;
  endfunction

  function automatic int hist_at(input int i);
    if (i < 0) return 0;
    return m_hist[i];
  endfunction

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] d;
    for (int i = 0; i < NSAMP; i++) d[i*INBITS +: INBITS] = 7'(v);
    return d;
  endfunction

  function automatic logic [W-1:0] rand_dat(input int lo, input int hi);
    logic [W-1:0] d;
    for (int i = 0; i < NSAMP; i++) d[i*INBITS +: INBITS] = 7'($urandom_range(hi, lo));
    return d;
  endfunction

  function automatic logic [W-1:0] pulse();
    logic [W-1:0] d;
    d = fill(BASELINE);
    d[INBITS-1:0] = 7'd93;
    return d;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input int want);
    n_total++;
    if (act === 32'(want)) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, want);
  endtask

  // Drive one cycle of stimulus and queue the outputs expected next cycle.
  task automatic step(input bit r, input logic [W-1:0] d, input bit w, input int th);
    exp_t e;
    bit   held;
    bit   issue;
    bit   apply;
    @(posedge clk);
    #1;
    rst = r;
    dat = d;
    wr  = w;
    thr = 16'(th);
    if (r) begin
      m_k = 0;
      m_hist.delete();
      m_power = 0;
      m_trig = 0;
      m_ack = 0;
      m_active = THR_DEF;
      m_pend = 0;
      m_pend_val = 0;
      m_last_trig = -100;
    end else begin
      held  = (m_k - m_last_trig) < HOLDOFF;
      issue = (m_k >= 3) && !held && (m_power > m_active);
      apply = (m_pend != 0) && !held && !issue;
      m_hist.push_back(clk_sum(d));
      m_trig = int'(issue);
      if (issue) m_last_trig = m_k + 1;
      m_ack = int'(apply);
      if (apply) begin
        m_active = m_pend_val;
        m_pend = 0;
      end
      if (w) begin
        m_pend = 1;
        m_pend_val = th;
      end
      m_k++;
      m_power = (hist_at(m_k - 3) + hist_at(m_k - 4)) % 65536;
    end
    e.cyc   = cyc + 1;
    e.power = m_power;
    e.trig  = m_trig;
    e.ack   = m_ack;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      check("power", 32'(power), mon_e.power);
      check("trig", 32'(trig), mon_e.trig);
      check("ack", 32'(ack), mon_e.ack);
    end
  end

  initial begin
    rst = 1'b1;
    dat = '0;
    wr  = 1'b0;
    thr = 16'd0;

    // Garbage under reset, then a quiet baseline stream.
    for (int i = 0; i < 3; i++) step(1'b1, rand_dat(0, 127), 1'b0, 0);
    repeat (10) step(1'b0, fill(BASELINE), 1'b0, 0);

    // Single-sample pulse against threshold 2000, then against 2116.
    step(1'b0, fill(BASELINE), 1'b1, 2000);
    repeat (3) step(1'b0, fill(BASELINE), 1'b0, 0);
    step(1'b0, pulse(), 1'b0, 0);
    repeat (10) step(1'b0, fill(BASELINE), 1'b0, 0);
    step(1'b0, fill(BASELINE), 1'b1, 2116);
    repeat (3) step(1'b0, fill(BASELINE), 1'b0, 0);
    step(1'b0, pulse(), 1'b0, 0);
    repeat (10) step(1'b0, fill(BASELINE), 1'b0, 0);

    // Constant zero input with the default threshold: periodic triggers.
    step(1'b1, fill(0), 1'b0, 0);
    repeat (15) step(1'b0, fill(0), 1'b0, 0);

    // Threshold write landing in holdoff, applied once armed again.
    for (int i = 0; i < 10 && m_trig == 0; i++) step(1'b0, fill(0), 1'b0, 0);
    step(1'b0, fill(BASELINE), 1'b1, 40000);
    repeat (6) step(1'b0, fill(BASELINE), 1'b0, 0);
    repeat (20) step(1'b0, fill(0), 1'b0, 0);

    // Reset mid-holdoff with a pending write.
    step(1'b1, fill(0), 1'b0, 0);
    for (int i = 0; i < 12 && m_trig == 0; i++) step(1'b0, fill(0), 1'b0, 0);
    step(1'b0, fill(0), 1'b1, 30000);
    step(1'b1, fill(0), 1'b0, 0);
    repeat (12) step(1'b0, fill(0), 1'b0, 0);

    // Random traffic, threshold writes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      int           mode;
      bit           r;
      bit           w;
      int           th;
      logic [W-1:0] d;
      mode = int'($urandom_range(3, 0));
      case (mode)
        0:       d = fill(BASELINE);
        1:       d = rand_dat(0, 93);
        2:       d = rand_dat(0, 127);
        default: d = rand_dat(30, 64);
      endcase
      r  = ($urandom_range(149, 0) == 0);
      w  = ($urandom_range(5, 0) == 0);
      th = ($urandom_range(1, 0) == 0) ? int'($urandom_range(40000, 0))
                                        : int'($urandom_range(20000, 1000));
      step(r, d, w, th);
    end

    repeat (2) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/beam_power_trigger.md
Name: beam_power_trigger

Overview:
- Sits directly downstream of the per-beam three-channel sub-beam adder.
- Consumes NSAMP unsigned 7-bit beam sums per clock.
- Removes the baseline, squares each sample and sums the squares over a sliding 2-clock window (2*NSAMP samples).
- Compares the window power against a programmable threshold and issues a single-cycle trigger, followed by a programmable holdoff.

Parameters:
- INBITS, 7, width of each incoming beam sample (unsigned).
- NSAMP, 8, samples per clock.
- BASELINE, 47, value subtracted from each sample before squaring.
- HOLDOFF, 4, cycles trigger is suppressed after a trigger (HOLDOFF >= 1).
- THRESH_DEFAULT, 16'd4000, threshold loaded at reset.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- dat_i  in  INBITS*NSAMP  beam samples; sample k at [INBITS*k +: INBITS], k=0 oldest.
- thresh_i  in  16  new threshold value.
- thresh_wr_i  in  1  request to load thresh_i.
- thresh_ack_o  out  1  one-cycle pulse when a requested threshold takes effect.
- power_o  out  16  current 2-clock window power (registered).
- trig_o  out  1  one-cycle trigger pulse.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - trig_o=0, thresh_ack_o=0, power_o=0.
  - All pipeline registers = 0; previous-clock sum = 0.
  - Active threshold = THRESH_DEFAULT; pending-threshold flag cleared.
  - FSM in WARMUP.
- Arithmetic:
  - d = dat - BASELINE, signed 8 bits; range -47..+46 for inputs 0..93. Inputs above 93 are not clamped; they are handled modulo width, with no saturation.
  - sq = d*d, 12 bits unsigned.
  - Clock sum S = sum of NSAMP squares, 15 bits.
  - Window W = S(n) + S(n-1), POWBITS=16 bits, no overflow for legal inputs.
- Pipeline: register after square (P1), after adder tree (P2), after window add (P3 = power_o), then trig_o registered from compare.
  - dat_i to power_o latency: 3 clocks.
  - dat_i to trig_o latency: 4 clocks.
- Compare: hit = (power_o > active threshold). Strictly greater; equal does not trigger.
- FSM states:
  - WARMUP: counts 3 clocks after reset release while the pipeline fills. trig_o is held 0 regardless of hit. Transitions to ARMED.
  - ARMED: if hit, then trig_o=1 for exactly one cycle, load holdoff counter = HOLDOFF, go to HOLDOFF.
  - HOLDOFF: trig_o=0. Counter decrements each clock. At counter==1 the next state is ARMED, so a re-trigger is possible HOLDOFF+1 cycles after the previous trig_o.
- Threshold update:
  - thresh_wr_i latches thresh_i into a pending register and sets the pending flag. A later write before application overwrites the pending value (last write wins).
  - Pending is applied on the first clock where the FSM is in ARMED or WARMUP and no hit is being issued that cycle. thresh_ack_o pulses 1 cycle on application.
  - Write during HOLDOFF: deferred until holdoff ends.
  - Write in the same cycle as application: the newly written value becomes pending. The previous pending value is applied and acked.
  - The compare uses the active threshold only, never the pending value.
- Reset mid-holdoff or mid-update: everything returns to reset values. A pending threshold is discarded with no ack.

Decomposition:
- Shared package beam_trig_pkg:
  - localparams POWBITS=16, SQBITS=12, SUMBITS=15.
  - typedef enum {WARMUP, ARMED, HOLDOFF} trig_state_t.
  - Function for the baseline-subtract width.
- One sub-module: beam_sq_sum. Per-sample subtract/square plus registered adder tree, producing S with 2-clock latency, reset via rst_i.
- FSM, window adder and threshold logic stay in the top module.

Test Plan:
- Reset release with all samples = 47:
  - power_o = 0 throughout.
  - trig_o never asserts.
  - Garbage before reset is flushed: power_o = 0 within 3 clocks.
- Sample 0 = 93, others 47, for one clock, threshold 2000:
  - power_o = 2116 at cycles +3 and +4, then 0.
  - trig_o pulses exactly once at +4; the +5 hit is suppressed by holdoff.
- Threshold equality: threshold 2116 with the same stimulus -> no trig.
- Constant all samples = 0, threshold 4000 (d=-47, W=35344):
  - trig_o pulses at cycle 4 (after warmup), then every HOLDOFF+1 = 5 cycles.
- Threshold write during HOLDOFF with thresh_i = 40000:
  - No ack until holdoff expires.
  - thresh_ack_o pulses on the first ARMED cycle.
  - No further triggers afterwards.
- Assert rst_i mid-HOLDOFF with a pending write:
  - No ack.
  - Threshold returns to 4000.
  - trig_o stays 0 for the 3 warmup clocks.
